// File: rtl/bus_master_port.sv
// bus_master_port
//
// Single-outstanding bus master between the CPU memory stage and the shared
// slave bus. A one-cycle CPU strobe is turned into a registered bus
// transaction. The port waits for the slave's ready, captures read data,
// and ends with one turnaround cycle so that two drivers never fight on
// the data bus. A slave that never answers is cut off after TIMEOUT ready
// samples, and the port reports it with an error pulse.
//
// Handshake: the CPU side has no ready signal. A cpu_req strobe is taken only
// while the port is idle, and cpu_busy tells the CPU when it is not. Every
// accepted access ends with exactly one cpu_done or one cpu_err pulse. On the
// bus side, request stays high until a rising edge samples ready as a clean
// 1'b1 (success) or until the wait budget runs out (timeout).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cpu_req/cpu_rw    access strobe and direction (1 = read)
//   cpu_addr          address, passed unchanged to the bus
//   cpu_wdata         write data
//   cpu_rdata         last successful read data
//   cpu_done/cpu_err  one-cycle completion / timeout pulses
//   cpu_busy          high whenever a transaction or turnaround is in flight
//   address/r_w       registered bus address and direction
//   request           registered bus request
//   data              bidirectional bus data; driven only for writes in REQ
//   ready             slave ready; z or x counts as not ready
module bus_master_port #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_rw,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_busy,
    output logic [31:0] address,
    output logic        r_w,
    output logic        request,
    inout  logic [31:0] data,
    input  logic        ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    // Last wait_cnt value that still allows another ready sample.
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] wait_cnt;
    logic [31:0] wbuf;
    logic        ready_hit;
    logic        accept;
    logic        finish_ok;
    logic        finish_err;

    // The ready line is shared and may float. Only a clean 1 counts.
    assign ready_hit = (ready === 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    accept     = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                // A ready on the last allowed sample still wins over timeout.
                if (ready_hit) begin
                    finish_ok  = 1'b1;
                    state_next = ST_TURN;
                end else if (wait_cnt == LAST_WAIT) begin
                    finish_err = 1'b1;
                    state_next = ST_TURN;
                end
            end
            ST_TURN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address   <= 32'd0;
            r_w       <= 1'b1;
            request   <= 1'b0;
            wbuf      <= 32'd0;
            wait_cnt  <= 16'd0;
            cpu_rdata <= 32'd0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
        end else begin
            cpu_done <= finish_ok;
            cpu_err  <= finish_err;
            if (accept) begin
                address  <= cpu_addr;
                r_w      <= cpu_rw;
                wbuf     <= cpu_wdata;
                request  <= 1'b1;
                wait_cnt <= 16'd0;
            end else if (finish_ok || finish_err) begin
                request <= 1'b0;
            end else if (state == ST_REQ) begin
                // Stops at LAST_WAIT because that value ends the transaction.
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (finish_ok && r_w) begin
                cpu_rdata <= data;
            end
        end
    end

    assign cpu_busy = (state != ST_IDLE);

    // The drive enable comes straight from the state register. Leaving REQ,
    // or an asynchronous reset, releases the bus right away.
    assign data = ((state == ST_REQ) && !r_w) ? wbuf : 32'bz;

endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port
//
// Bench for bus_master_port. A transaction-level model predicts every output
// from the accept edge and the slave's planned ready delay:
//   end edge = start + min(k, TIMEOUT), request high before the end edge,
//   done or err in the end cycle, busy through the end cycle, and the next
//   accept possible two edges after the end edge.
// A slave model drives ready and read data on the k-th sampling edge. A
// compare process checks all outputs on every falling edge. Directed cases
// pin the model with hand-computed literals.
module tb_bus_master_port;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_err;
  logic        cpu_busy;
  logic [31:0] address;
  logic        r_w;
  logic        request;
  tri0  [31:0] data;
  wire         ready;

  // slave-side drive
  logic        slv_rdy = 1'b0;
  logic        slv_drv = 1'b0;
  logic [31:0] slv_data = 32'd0;
  assign data  = slv_drv ? slv_data : 32'bz;
  assign ready = slv_rdy ? 1'b1 : 1'bz;

  // plan attached to the strobe currently on cpu_req
  int          plan_k = 1;
  logic [31:0] plan_rdata = 32'd0;

  int total = 0;
  int bad = 0;
  int req_cnt = 0;

  bus_master_port #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .address(address), .r_w(r_w), .request(request), .data(data),
    .ready(ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  // ---------------- transaction model ----------------
  int          edge_n = 0;
  bit          in_txn = 1'b0;
  int          t_start = 0;
  int          t_end = 0;
  int          m_k = 1;
  bit          m_ok = 1'b0;
  logic        m_rw = 1'b1;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_plan_rdata = 32'd0;
  logic [31:0] m_rdata = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n = 0;
      in_txn = 1'b0;
      m_addr = 32'd0;
      m_rw = 1'b1;
      m_rdata = 32'd0;
    end else begin
      edge_n++;
      if ((!in_txn || edge_n >= t_end + 2) && cpu_req) begin
        in_txn = 1'b1;
        t_start = edge_n;
        m_k = plan_k;
        m_ok = (plan_k <= TIMEOUT);
        t_end = t_start + (m_ok ? plan_k : TIMEOUT);
        m_addr = cpu_addr;
        m_rw = cpu_rw;
        m_wdata = cpu_wdata;
        m_plan_rdata = plan_rdata;
      end else if (in_txn && edge_n == t_end && m_ok && m_rw) begin
        m_rdata = m_plan_rdata;
      end
    end
  end

  // Slave answers during the cycle before its k-th sampling edge. With
  // k = TIMEOUT+1 that cycle is the turnaround, where it must be ignored.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slv_rdy = 1'b0;
      slv_drv = 1'b0;
    end else begin
      #1;
      slv_rdy = in_txn && (m_k <= TIMEOUT + 1) && (edge_n == t_start + m_k - 1);
      slv_drv = slv_rdy && m_rw;
      slv_data = m_plan_rdata;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic        e_req, e_done, e_err, e_busy;
  logic [31:0] e_data;

  always @(negedge clk) begin
    e_req  = in_txn && (edge_n >= t_start) && (edge_n < t_end);
    e_done = in_txn && (edge_n == t_end) && m_ok;
    e_err  = in_txn && (edge_n == t_end) && !m_ok;
    e_busy = in_txn && (edge_n <= t_end);
    if (e_req && !m_rw) e_data = m_wdata;
    else if (slv_drv)   e_data = slv_data;
    else                e_data = 32'd0;
    chk("request", {31'd0, request}, {31'd0, e_req});
    chk("cpu_done", {31'd0, cpu_done}, {31'd0, e_done});
    chk("cpu_err", {31'd0, cpu_err}, {31'd0, e_err});
    chk("cpu_busy", {31'd0, cpu_busy}, {31'd0, e_busy});
    chk("address", address, m_addr);
    chk("r_w", {31'd0, r_w}, {31'd0, m_rw});
    chk("cpu_rdata", cpu_rdata, m_rdata);
    chk("data", data, e_data);
    if (request === 1'b1) req_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                        input int k, input logic [31:0] rd);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
    plan_k = k; plan_rdata = rd;
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  // lat = cycles from the accept edge to the done/err cycle, -1 when no pulse arrives
  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                         input int k, input logic [31:0] rd,
                         output int lat, output logic got_done, output logic got_err);
    req_cnt = 0;
    strobe(rw, addr, wd, k, rd);
    lat = -1; got_done = 1'b0; got_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_done === 1'b1 || cpu_err === 1'b1) begin
        got_done = cpu_done; got_err = cpu_err; lat = i;
        break;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  int          lat;
  logic        gd, ge;
  int          dn;
  logic [8:0]  busy_pat;

  initial begin
    #1 rst_n = 1'b0;
    #3;
    chk("rst_request", {31'd0, request}, 32'd0);
    chk("rst_r_w", {31'd0, r_w}, 32'd1);
    chk("rst_address", address, 32'd0);
    chk("rst_busy", {31'd0, cpu_busy}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_data", data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // timer read, ready immediately
    run_txn(1'b1, 32'h03FF_FFFC, 32'd0, 1, 32'd35, lat, gd, ge);
    chk("timer_lat", lat, 32'd1);
    chk("timer_done", {31'd0, gd}, 32'd1);
    chk("timer_err", {31'd0, ge}, 32'd0);
    chk("timer_rdata", cpu_rdata, 32'd35);
    chk("timer_req_cycles", req_cnt, 32'd1);

    // write, ready on the 4th sample
    run_txn(1'b0, 32'h0000_0040, 32'hA5A5_0001, 4, 32'hDEAD_BEEF, lat, gd, ge);
    chk("wr_lat", lat, 32'd4);
    chk("wr_done", {31'd0, gd}, 32'd1);
    chk("wr_rdata_kept", cpu_rdata, 32'd35);
    chk("wr_req_cycles", req_cnt, 32'd4);

    // unmapped read, ready never comes
    run_txn(1'b1, 32'h0000_1000, 32'd0, 1000, 32'h1111_1111, lat, gd, ge);
    chk("to_lat", lat, 32'd16);
    chk("to_err", {31'd0, ge}, 32'd1);
    chk("to_done", {31'd0, gd}, 32'd0);
    chk("to_rdata_kept", cpu_rdata, 32'd35);
    chk("to_req_cycles", req_cnt, 32'd16);

    // ready on the last allowed sample, then one sample too late
    run_txn(1'b1, 32'h0000_0010, 32'd0, 16, 32'h00C0_FFEE, lat, gd, ge);
    chk("edge16_lat", lat, 32'd16);
    chk("edge16_done", {31'd0, gd}, 32'd1);
    chk("edge16_err", {31'd0, ge}, 32'd0);
    chk("edge16_rdata", cpu_rdata, 32'h00C0_FFEE);
    run_txn(1'b1, 32'h0000_0014, 32'd0, 17, 32'h2222_2222, lat, gd, ge);
    chk("edge17_err", {31'd0, ge}, 32'd1);
    chk("edge17_done", {31'd0, gd}, 32'd0);
    chk("edge17_rdata", cpu_rdata, 32'h00C0_FFEE);

    // strobe every cycle: accepts every third edge
    busy_pat = 9'b011_011_011;
    dn = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 32'h03FF_FFFD;
    plan_k = 1; plan_rdata = 32'd77;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("b2b_busy", {31'd0, cpu_busy}, {31'd0, busy_pat[i]});
      if (cpu_done === 1'b1) dn++;
    end
    chk("b2b_done_count", dn, 32'd3);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (4) @(posedge clk);

    // reset in the second REQ cycle of a write
    strobe(1'b0, 32'h0000_0080, 32'hA5A5_0001, 10, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_request", {31'd0, request}, 32'd0);
    chk("mid_rst_data", data, 32'd0);
    chk("mid_rst_busy", {31'd0, cpu_busy}, 32'd0);
    chk("mid_rst_done", {31'd0, cpu_done}, 32'd0);
    chk("mid_rst_err", {31'd0, cpu_err}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b1, 32'h03FF_FFFC, 32'd0, 2, 32'h0000_1234, lat, gd, ge);
    chk("post_rst_lat", lat, 32'd2);
    chk("post_rst_rdata", cpu_rdata, 32'h0000_1234);

    // randomized traffic, including strobes while busy
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      cpu_req = ($urandom_range(0, 2) == 0);
      cpu_rw = 1'($urandom_range(0, 1));
      cpu_addr = $urandom;
      cpu_wdata = $urandom;
      plan_rdata = $urandom;
      case ($urandom_range(0, 9))
        7:       plan_k = $urandom_range(14, 17);
        8, 9:    plan_k = (($urandom_range(0, 1) == 0) ? 1000 : $urandom_range(1, 16));
        default: plan_k = $urandom_range(1, 5);
      endcase
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
# bus_master_port

Single-outstanding bus master that sits between the CPU memory stage and the shared slave bus, directly upstream of the memory-mapped slaves such as the millisecond timer at 0x3FFFFFC–0x3FFFFFD. It turns a one-cycle CPU access strobe into a registered bus transaction: it drives `address`/`r_w`/`request`, drives `data` on writes, waits for a slave `ready`, and captures read data. Missing or never-ready slaves are terminated by a timeout with an error pulse. A turnaround cycle after every transaction prevents drive contention on `data`.

## Interface
- `TIMEOUT`, 16: maximum number of `ready` sampling edges per transaction; legal range 1–65535.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  one-cycle access strobe; sampled only in IDLE.
- `cpu_rw`  in  1  1 = read, 0 = write.
- `cpu_addr`  in  32  byte/word address, passed unchanged to the bus.
- `cpu_wdata`  in  32  write data.
- `cpu_rdata`  out  32  captured read data; holds until the next successful read.
- `cpu_done`  out  1  one-cycle pulse on successful completion.
- `cpu_err`  out  1  one-cycle pulse on timeout.
- `cpu_busy`  out  1  high whenever the state is not IDLE.
- `address`  out  32  bus address, registered.
- `r_w`  out  1  bus direction, registered; 1 = read.
- `request`  out  1  bus request, registered.
- `data`  inout  32  bus data; driven only during a write in REQ, else 32'bz.
- `ready`  in  1  slave ready, shared tristate line; only a clean 1'b1 counts, z/x = not ready.

## Operation
- States: IDLE, REQ, TURN.
- IDLE: on an edge with `cpu_req`=1, register `cpu_addr`→`address`, `cpu_rw`→`r_w`, `cpu_wdata`→write buffer. Set `request`=1 and `wait_cnt`=0, then go to REQ.
- REQ: on each edge, test `ready === 1'b1`.
  - Ready: if `r_w`=1, capture `data`→`cpu_rdata`. Pulse `cpu_done`, clear `request`, go to TURN.
  - Not ready and `wait_cnt`==TIMEOUT-1: pulse `cpu_err`, clear `request`, go to TURN. `cpu_rdata` is unchanged.
  - Otherwise: increment `wait_cnt` (16-bit; cannot wrap because it stops at TIMEOUT-1).
- TURN: one cycle with `request`=0 and `data` released. Return to IDLE unconditionally.
- `cpu_req` in REQ or TURN is ignored and not queued. The CPU must wait for `cpu_done` or `cpu_err` and then re-strobe.
- Write drive enable = (state==REQ) & ~`r_w`. It is deasserted in the same edge that leaves REQ.
- `cpu_done` and `cpu_err` are mutually exclusive. Ready on the final allowed edge counts as success, not error.

## Timing
- Reset (async assert, synchronous release), all outputs: `request`=0, `address`=0, `r_w`=1, `data`=z, `cpu_rdata`=0, `cpu_done`=0, `cpu_err`=0, `cpu_busy`=0, state IDLE, `wait_cnt`=0.
- Reset mid-transaction: `request` drops and `data` releases immediately, with no done or err pulse.
- Accept at edge E0. `request` is high in cycle E0–E1.
- Slave ready in the first cycle: sampled at E1. `cpu_done` is high and state is TURN in E1–E2. IDLE in E2–E3. The next strobe can be accepted at E3.
- Best case is one access per 3 cycles. Transaction latency strobe→done = 1 + (ready edges waited).
- Timeout case: `cpu_err` is asserted in the cycle after edge E0+TIMEOUT.
- `cpu_busy` is high from the cycle after accept through the TURN cycle.

## Test plan
- Read the timer slave at 0x3FFFFFC, with the slave returning 32'd35 and ready immediately → `request` high for exactly 1 cycle, `cpu_done` at E1, `cpu_rdata`=35, `cpu_err` never high.
- Write 0xA5A5_0001 to a slave with ready after 3 cycles → `data`=0xA5A5_0001 during REQ only, z in TURN, `cpu_done` once, `cpu_rdata` unchanged.
- Read unmapped 0x0000_1000 (ready stays z), TIMEOUT=16 → `cpu_err` pulses at E16, `cpu_done` 0, `request` low afterward, `cpu_rdata` holds its previous value.
- Ready asserted exactly on the 16th sampling edge with TIMEOUT=16 → `cpu_done`=1, `cpu_err`=0. Ready on the 17th → err only.
- Back-to-back strobes every cycle → accepts at E0, E3, E6; strobes at E1 and E2 are dropped; `cpu_busy` pattern 1,1,0 repeats.
- `rst_n` low in the 2nd cycle of REQ during a write → `request`=0 and `data`=z without a clock edge, no pulses, IDLE after release; a fresh read then completes normally.
